// File: rtl/memory_ram.sv
// memory_ram: single-port synchronous RAM, registered read, synchronous write.
// Ports: clk, rst_n, enable, ReadWrite(1=rd), Address, DataIn -> DataOut.
module memory_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 65536
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  ReadWrite,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] DataIn,
  output logic [DATA_WIDTH-1:0] DataOut
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = DEPTH[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] Mem [0:DEPTH-1];

  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic [IDX_W-1:0]      idx;
  logic                  in_range;
  logic                  rd_en;
  logic                  wr_en;

  assign idx      = Address[IDX_W-1:0];
  assign in_range = ({1'b0, Address} < DEPTH_W);
  assign rd_en    = enable & ReadWrite;
  // An unknown address makes in_range unknown, so the write is skipped.
  assign wr_en    = enable & ~ReadWrite & in_range;

  // Out-of-range reads return zero; an unknown address merges to all-X.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = (!in_range) ? '0 : Mem[idx];
    end
  end

  // Storage is never reset so preloaded contents survive rst_n.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      Mem[idx] <= DataIn;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign DataOut = rdata_q;

endmodule

// File: tb/tb_memory_ram.sv
// tb_memory_ram: directed bench with a behavioural memory model.
// Drives a full-depth and a 1024-deep instance from the same buses.
module tb_memory_ram;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        rw;
  logic [15:0] addr;
  logic [31:0] din;
  logic [31:0] dout_b;
  logic [31:0] dout_s;

  int total;
  int passed;

  logic [31:0] bm [0:65535];
  logic [31:0] sm [0:1023];
  logic [31:0] eb;
  logic [31:0] es;

  memory_ram u_big (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (en),
    .ReadWrite (rw),
    .Address   (addr),
    .DataIn    (din),
    .DataOut   (dout_b)
  );

  memory_ram #(.DEPTH(1024)) u_small (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (en),
    .ReadWrite (rw),
    .Address   (addr),
    .DataIn    (din),
    .DataOut   (dout_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask

  // Model: read returns stored word, or 0 beyond DEPTH; writes beyond
  // DEPTH vanish; reset clears only the output.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eb = 32'h0;
      es = 32'h0;
    end else if (en) begin
      if (rw) begin
        eb = bm[int'(addr)];
        es = (int'(addr) < 1024) ? sm[int'(addr)] : 32'h0;
      end else begin
        bm[int'(addr)] = din;
        if (int'(addr) < 1024) sm[int'(addr)] = din;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_big", dout_b, eb);
    chk("model_small", dout_s, es);
  end

  task automatic rd(input logic [15:0] a);
    @(negedge clk);
    en = 1'b1; rw = 1'b1; addr = a; din = $urandom;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    en = 1'b1; rw = 1'b0; addr = a; din = d;
    @(posedge clk); #1;
  endtask

  initial begin
    total = 0;
    passed = 0;
    rst_n = 1'b0;
    en = 1'b0; rw = 1'b1; addr = 16'h0; din = 32'h0;
    for (int i = 0; i < 8; i++) begin
      u_big.Mem[i]   = 32'h11111111 * i;
      u_small.Mem[i] = 32'h11111111 * i;
      bm[i] = 32'h11111111 * i;
      sm[i] = 32'h11111111 * i;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_big", dout_b, 32'h0);
    chk("reset_small", dout_s, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      rd(16'(i));
      chk("preload_rd", dout_b, 32'h11111111 * i);
    end

    wr(16'h1234, 32'hDEADBEEF);
    chk("no_write_through", dout_b, 32'h77777777);
    rd(16'h1234);
    chk("rd_1234", dout_b, 32'hDEADBEEF);
    chk("rd_1234_small_oor", dout_s, 32'h0);
    wr(16'hFFFF, 32'hCAFEF00D);
    rd(16'hFFFF);
    chk("rd_ffff", dout_b, 32'hCAFEF00D);

    rd(16'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      en = 1'b0; rw = i[0]; addr = 16'(i); din = 32'hF0F0_0000 + i;
    end
    @(posedge clk); #1;
    chk("idle_hold", dout_b, 32'h33333333);
    rd(16'd0);
    chk("idle_no_write", dout_b, 32'h0);
    rd(16'd3);
    chk("idle_no_write3", dout_b, 32'h33333333);

    rd(16'd2);
    wr(16'd5, 32'hA5A5A5A5);
    chk("hold_during_wr", dout_b, 32'h22222222);
    rd(16'd5);
    chk("rd_5", dout_b, 32'hA5A5A5A5);
    chk("rd_5_small", dout_s, 32'hA5A5A5A5);

    rd(16'd4);
    chk("rd_4", dout_b, 32'h44444444);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_big", dout_b, 32'h0);
    chk("async_rst_small", dout_s, 32'h0);
    @(negedge clk);
    en = 1'b1; rw = 1'b0; addr = 16'd6; din = 32'hBAD0BAD0;
    @(negedge clk);
    rw = 1'b1; addr = 16'd5;
    @(posedge clk); #1;
    chk("rd_blocked_in_rst", dout_b, 32'h0);
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b1;
    rd(16'd4);
    chk("retained_4", dout_b, 32'h44444444);
    rd(16'd6);
    chk("wr_blocked_in_rst", dout_b, 32'h66666666);

    wr(16'd2000, 32'h12345678);
    rd(16'd2000);
    chk("oor_rd_small", dout_s, 32'h0);
    chk("rd_2000_big", dout_b, 32'h12345678);
    wr(16'd1023, 32'h0BADF00D);
    rd(16'd1023);
    chk("top_small", dout_s, 32'h0BADF00D);
    rd(16'd1);
    chk("rd_1_small", dout_s, 32'h11111111);
    rd(16'd7);
    chk("rd_7_small", dout_s, 32'h77777777);

    @(negedge clk);
    en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
